spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Byte-level register-access controller directly downstream of the SPI slave shift stage.
- Consumes each received byte (rx_data/rx_rdy) and decodes a command/address byte followed by data bytes.
- Writes or reads an internal register file with address auto-increment.
- Returns read data to the slave by loading tx_data and pulsing tx_latch, which also clears the slave's ready flag.

Parameters:
- NUM_REGS, 6, number of 8-bit registers implemented.
- AW, 3, register index width; NUM_REGS <= 2**AW.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- sclk  in  1  clock; all state updates on posedge sclk.
- rst  in  1  reset, asynchronous, active-high.
- ss  in  1  frame active when high; low = no transaction in progress.
- rx_data  in  8  received byte from shift stage.
- rx_rdy  in  1  received-byte-ready level from shift stage; held until tx_latch.
- tx_data  out  8  byte to load into shift stage for next transfer.
- tx_latch  out  1  one-cycle load strobe to shift stage; clears rx_rdy upstream.
- wr_stb  out  1  one-cycle pulse when a register is written.
- wr_addr  out  AW  index written on wr_stb.
- regs_flat  out  NUM_REGS*8  all registers, reg[i] at bits [8i+7:8i].
- addr_err  out  1  sticky out-of-range flag; constant 0 unless SPI_CTRL_ADDR_CHECK_EN.

Behaviour:
- Reset (async): state=CMD, addr=0, all regs=RST_VAL, tx_data=0, tx_latch=0, wr_stb=0, addr_err=0, rx_rdy_q=0.
- Byte event: rx_rdy & ~rx_rdy_q, with rx_rdy_q registered each sclk. At most one event per rising edge of rx_rdy.
- Sampling ss low on a sclk edge forces state=CMD. Takes priority over a simultaneous byte event, which is discarded. Registers are unaffected.
- Command byte: bit7 = 1 write, 0 read; bits[6:0] = start address (7-bit, held in addr).
- FSM:
  - CMD, on event: addr<=rx_data[6:0]. If bit7=1, go to WR; else go to RD.
  - WR, on event: reg[addr[AW-1:0]]<=rx_data; wr_stb=1 and wr_addr=addr for that cycle; addr increments; stay in WR.
  - RD, on event: the byte is ignored as data; addr increments; stay in RD.
- tx path, every byte event, same edge as the state update:
  - From CMD with read: tx_data<=reg[start addr].
  - From RD: tx_data<=reg[addr+1] (pre-fetch of the next location).
  - From CMD with write, or from WR: tx_data<=8'h00.
  - In all cases tx_latch<=1 for exactly one cycle, so tx_data is stable when tx_latch is high.
- Latency: event edge -> tx_latch/wr_stb high on the following sclk edge (1 cycle).
- Address wrap without the macro: index = addr mod NUM_REGS; increment wraps NUM_REGS-1 -> 0.
- A register written and read in the same frame returns the new value.
- rx_rdy held high across multiple cycles produces exactly one event.
- Reset mid-frame aborts the transaction; no partial write is committed.

Optional Feature:
- Macro: SPI_CTRL_ADDR_CHECK_EN.
- Enabled:
  - addr increments as 7-bit with no wrap (7F -> 00).
  - Any access with addr >= NUM_REGS: write ignored (no wr_stb), read returns 8'hFF, addr_err set sticky until rst.
- Disabled: modulo wrap as above; addr_err tied 0.

Decomposition:
- Package spi_ctrl_pkg:
  - state encoding (CMD, WR, RD);
  - CMD_WR_BIT=7;
  - READ_OOR_VAL=8'hFF;
  - TX_DUMMY=8'h00.
- One natural sub-module, spi_ctrl_regfile: NUM_REGS x 8 storage, one write port, two combinational read ports (current and next index), flat output.

Test Plan:
- Reset: assert rst mid-frame with regs written -> all regs 00, tx_latch 0, state CMD, addr_err 0.
- Write burst: ss=1, bytes 82,11,22,33 -> reg2=11, reg3=22, reg4=33; three wr_stb pulses with wr_addr 2,3,4; four tx_latch pulses with tx_data 00.
- Read burst: after write burst, bytes 03,xx,xx -> tx_data 22 (after cmd), 33, then reg5 value 00; no wr_stb.
- Wrap (macro off): bytes 85,AA,BB -> reg5=AA, reg0=BB.
- Same wrap bytes with SPI_CTRL_ADDR_CHECK_EN -> reg5=AA, no write to reg0, addr_err=1. Subsequent read of 07 returns FF.
- Frame abort: bytes 81,55 then ss=0 for one edge, then byte 01 with ss=1 -> treated as a read command, tx_data=55; rx_rdy held high 5 cycles gives a single event.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding and byte constants for the SPI register controller
package spi_ctrl_pkg;
  typedef enum logic [1:0] {CMD, WR, RD} state_t;
  localparam int CMD_WR_BIT = 7;
  localparam logic [7:0] READ_OOR_VAL = 8'hFF;
  localparam logic [7:0] TX_DUMMY = 8'h00;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_byte_if: byte handshake between SPI shift stage (master) and register controller (slave)
// ss/rx_data/rx_rdy flow to the controller; tx_data/tx_latch flow back to the shift stage.
interface spi_byte_if;
  logic ss;
  logic [7:0] rx_data;
  logic rx_rdy;
  logic [7:0] tx_data;
  logic tx_latch;
  modport master (output ss, rx_data, rx_rdy, input tx_data, tx_latch);
  modport slave (input ss, rx_data, rx_rdy, output tx_data, tx_latch);
endinterface

// File: rtl/spi_ctrl_regfile.sv
// spi_ctrl_regfile: NUM_REGS x 8 register storage, one write port, two combinational read ports
// Ports: sclk/rst, we/wa/wd write port, ra0/rd0 and ra1/rd1 read ports, flat = all registers.
module spi_ctrl_regfile #(
  parameter int NUM_REGS = 6,
  parameter int AW = 3,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic sclk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [7:0] wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [7:0] rd0,
  output logic [7:0] rd1,
  output logic [NUM_REGS*8-1:0] flat
);
  logic [7:0] mem [NUM_REGS];
  always_ff @(posedge sclk or posedge rst)
    if (rst) for (int i = 0; i < NUM_REGS; i++) mem[i] <= RST_VAL;
    else if (we && int'(wa) < NUM_REGS) mem[wa] <= wd;
  assign rd0 = int'(ra0) < NUM_REGS ? mem[ra0] : RST_VAL;
  assign rd1 = int'(ra1) < NUM_REGS ? mem[ra1] : RST_VAL;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign flat[8*g +: 8] = mem[g];
  end
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command/address/data byte decoder driving a register file behind an SPI slave
// Ports: sclk, rst (async, active-high), bus (spi_byte_if.slave: ss, rx_data, rx_rdy, tx_data,
// tx_latch), wr_stb/wr_addr write notification, regs_flat all registers, addr_err sticky flag.
// Define SPI_CTRL_ADDR_CHECK_EN for range-checked, non-wrapping addressing with addr_err.
module spi_reg_ctrl import spi_ctrl_pkg::*; #(
  parameter int NUM_REGS = 6,
  parameter int AW = 3,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic sclk,
  input  logic rst,
  spi_byte_if.slave bus,
  output logic wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic addr_err
);
`ifdef SPI_CTRL_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  function automatic logic [AW-1:0] idx(input logic [6:0] a);
    return CHK ? a[AW-1:0] : AW'(a % 7'(NUM_REGS));
  endfunction
  function automatic logic oor(input logic [6:0] a);
    return CHK && a >= 7'(NUM_REGS);
  endfunction
  state_t state, state_d;
  logic [6:0] addr, addr_d, addr_inc, cur;
  logic rx_rdy_q, ev, we, latch_d, err_d;
  logic [7:0] tx_d, rd_cur, rd_nxt;
  assign ev = bus.rx_rdy & ~rx_rdy_q;
  assign cur = state == CMD ? bus.rx_data[6:0] : addr;
  // without range checking, the increment also normalises addr into 0..NUM_REGS-1
  assign addr_inc = CHK ? addr + 7'd1 :
                    idx(addr) == AW'(NUM_REGS - 1) ? 7'd0 : 7'(idx(addr)) + 7'd1;
  spi_ctrl_regfile #(.NUM_REGS(NUM_REGS), .AW(AW), .RST_VAL(RST_VAL)) u_rf (
    .sclk(sclk), .rst(rst), .we(we), .wa(idx(addr)), .wd(bus.rx_data),
    .ra0(idx(cur)), .ra1(idx(addr_inc)), .rd0(rd_cur), .rd1(rd_nxt), .flat(regs_flat)
  );
  always_comb begin
    state_d = state;
    addr_d = addr;
    tx_d = bus.tx_data;
    latch_d = 1'b0;
    we = 1'b0;
    err_d = addr_err;
    if (!bus.ss) state_d = CMD;
    else if (ev) begin
      latch_d = 1'b1;
      tx_d = TX_DUMMY;
      if (state == CMD) begin
        addr_d = bus.rx_data[6:0];
        state_d = bus.rx_data[CMD_WR_BIT] ? WR : RD;
        if (!bus.rx_data[CMD_WR_BIT]) begin
          tx_d = oor(cur) ? READ_OOR_VAL : rd_cur;
          err_d = addr_err | oor(cur);
        end
      end else if (state == WR) begin
        we = !oor(addr);
        err_d = addr_err | oor(addr);
        addr_d = addr_inc;
      end else begin
        addr_d = addr_inc;
        tx_d = oor(addr_inc) ? READ_OOR_VAL : rd_nxt;
        err_d = addr_err | oor(addr_inc);
      end
    end
  end
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state <= CMD;
      addr <= '0;
      rx_rdy_q <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_latch <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      rx_rdy_q <= bus.rx_rdy;
      bus.tx_data <= tx_d;
      bus.tx_latch <= latch_d;
      wr_stb <= we;
      wr_addr <= idx(addr);
      addr_err <= err_d;
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed vector table plus corner-case sequences for spi_reg_ctrl
module tb_spi_reg_ctrl;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic wr_stb, addr_err;
  logic [2:0] wr_addr;
  logic [47:0] regs_flat;
  int total = 0, bad = 0, n_latch = 0, n_wr = 0;
  spi_byte_if bus();
  spi_reg_ctrl dut (.sclk(sclk), .rst(rst), .bus(bus), .wr_stb(wr_stb), .wr_addr(wr_addr),
                    .regs_flat(regs_flat), .addr_err(addr_err));
  always #5 sclk = ~sclk;
  always @(negedge sclk) begin
    if (bus.tx_latch) n_latch++;
    if (wr_stb) n_wr++;
  end
  typedef struct {
    logic nf;
    logic [7:0] b;
    logic [7:0] tx;
    logic w;
    logic [2:0] wa;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, output logic [7:0] tx, output logic w,
                      output logic [2:0] wa, output logic ok);
    @(negedge sclk);
    bus.rx_data = b;
    bus.rx_rdy = 1'b1;
    ok = 1'b0;
    tx = 'x;
    w = 'x;
    wa = 'x;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge sclk);
      if (bus.tx_latch) begin
        ok = 1'b1;
        tx = bus.tx_data;
        w = wr_stb;
        wa = wr_addr;
      end
    end
    bus.rx_rdy = 1'b0;
    @(negedge sclk);
    chk("latch_one_cycle", bus.tx_latch, 1'b0);
  endtask
  task automatic frame;
    @(negedge sclk);
    bus.ss = 1'b0;
    @(negedge sclk);
    bus.ss = 1'b1;
  endtask
  logic [7:0] tx;
  logic w, ok;
  logic [2:0] wa;
  int l0, w0;
  initial begin
    bus.ss = 1'b0;
    bus.rx_data = '0;
    bus.rx_rdy = 1'b0;
    repeat (3) @(negedge sclk);
    chk("rst_regs", regs_flat, 48'h0);
    chk("rst_latch", bus.tx_latch, 1'b0);
    chk("rst_err", addr_err, 1'b0);
    rst = 1'b0;
    v.push_back('{1'b1, 8'h82, 8'h00, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'h11, 8'h00, 1'b1, 3'd2});
    v.push_back('{1'b0, 8'h22, 8'h00, 1'b1, 3'd3});
    v.push_back('{1'b0, 8'h33, 8'h00, 1'b1, 3'd4});
    v.push_back('{1'b1, 8'h03, 8'h22, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'h5A, 8'h33, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'hC3, 8'h00, 1'b0, 3'd0});
    v.push_back('{1'b1, 8'h85, 8'h00, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'hAA, 8'h00, 1'b1, 3'd5});
    v.push_back('{1'b0, 8'hBB, 8'h00, !CHK, 3'd0});
    v.push_back('{1'b1, 8'h05, 8'hAA, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'h00, CHK ? 8'hFF : 8'hBB, 1'b0, 3'd0});
    v.push_back('{1'b1, 8'h07, CHK ? 8'hFF : 8'h00, 1'b0, 3'd0});
    v.push_back('{1'b0, 8'h00, CHK ? 8'hFF : 8'h11, 1'b0, 3'd0});
    foreach (v[k]) begin
      if (v[k].nf) frame();
      send(v[k].b, tx, w, wa, ok);
      chk($sformatf("v%0d_latch", k), ok, 1'b1);
      chk($sformatf("v%0d_tx", k), tx, v[k].tx);
      chk($sformatf("v%0d_wr", k), w, v[k].w);
      if (v[k].w) chk($sformatf("v%0d_wa", k), wa, v[k].wa);
    end
    chk("regs_after_table", regs_flat, CHK ? 48'hAA33_2211_0000 : 48'hAA33_2211_00BB);
    chk("addr_err", addr_err, CHK);
    chk("wr_count", n_wr, CHK ? 4 : 5);
    frame();
    send(8'h81, tx, w, wa, ok);
    chk("abort_cmd_tx", tx, 8'h00);
    send(8'h55, tx, w, wa, ok);
    chk("abort_wr", {w, wa}, {1'b1, 3'd1});
    l0 = n_latch;
    @(negedge sclk);
    bus.ss = 1'b0;
    bus.rx_data = 8'h99;
    bus.rx_rdy = 1'b1;
    @(negedge sclk);
    bus.ss = 1'b1;
    repeat (2) @(negedge sclk);
    bus.rx_rdy = 1'b0;
    chk("ss_low_discard", n_latch - l0, 0);
    send(8'h01, tx, w, wa, ok);
    chk("abort_read_tx", tx, 8'h55);
    chk("abort_read_nowr", w, 1'b0);
    chk("abort_regs", regs_flat[23:8], 16'h1155);
    l0 = n_latch;
    w0 = n_wr;
    @(negedge sclk);
    bus.rx_data = 8'h00;
    bus.rx_rdy = 1'b1;
    repeat (5) @(negedge sclk);
    bus.rx_rdy = 1'b0;
    @(negedge sclk);
    chk("held_single_event", n_latch - l0, 1);
    chk("held_prefetch", bus.tx_data, 8'h11);
    chk("held_nowr", n_wr - w0, 0);
    frame();
    send(8'h80, tx, w, wa, ok);
    @(negedge sclk);
    bus.rx_data = 8'h77;
    bus.rx_rdy = 1'b1;
    rst = 1'b1;
    @(negedge sclk);
    chk("midrst_regs", regs_flat, 48'h0);
    chk("midrst_latch", bus.tx_latch, 1'b0);
    chk("midrst_wr", wr_stb, 1'b0);
    chk("midrst_err", addr_err, 1'b0);
    rst = 1'b0;
    bus.rx_rdy = 1'b0;
    send(8'h80, tx, w, wa, ok);
    chk("post_rst_cmd", {ok, w}, 2'b10);
    send(8'h12, tx, w, wa, ok);
    chk("post_rst_wr", {w, wa}, {1'b1, 3'd0});
    chk("post_rst_reg0", regs_flat[7:0], 8'h12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
